// File: rtl/segment_pkg.sv
`default_nettype none
//============================================================================
// Module      : segment_pkg
// Description : Shared constants and helpers for the multiplexed hex
//               display scanner (digit count, nibble width, default scan
//               divider, nibble extraction helper).
// Revision    : 1.0 - initial release
//============================================================================
package segment_pkg;

    localparam int SCAN_DIV_DEFAULT = 50000;       // clocks per digit slot
    localparam int DIGITS           = 8;           // digits on the display
    localparam int NIBBLE_W         = 4;           // bits per hex digit
    localparam int VALUE_W          = DIGITS * NIBBLE_W;
    localparam int IDX_W            = $clog2(DIGITS);

    typedef logic [IDX_W-1:0]    digit_idx_t;
    typedef logic [NIBBLE_W-1:0] nibble_t;

    // Nibble i of a packed display value (nibble i is bits 4i+3:4i).
    function automatic nibble_t nibble_at(input logic [VALUE_W-1:0] v,
                                          input digit_idx_t         i);
        return v[int'(i)*NIBBLE_W +: NIBBLE_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/scan_prescaler.sv
`default_nettype none
//============================================================================
// Module      : scan_prescaler
// Description : Free-running modulo-DIV counter; tick is high during the
//               cycle the count equals DIV-1.
//   clk  - system clock (rising edge)
//   rst  - synchronous active-high reset, count returns to 0
//   tick - one cycle in every DIV
// Revision    : 1.0 - initial release
//============================================================================
module scan_prescaler #(
    parameter int DIV = 50000               // minimum 2
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_last;

    assign w_last = (r_count == C_LAST);
    assign tick   = w_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/segment_scan.sv
`default_nettype none
//============================================================================
// Module      : segment_scan
// Description : Eight-digit multiplexed hex display scanner with tear-free
//               frame-aligned value updates, leading-zero blanking and a
//               per-digit enable mask.
//   clk        - system clock (rising edge)
//   rst        - synchronous active-high reset
//   load       - one-cycle strobe capturing value
//   value      - eight hex nibbles, nibble i = value[4i+3:4i]
//   blank_lz   - enable leading-zero blanking (digit 0 always shown)
//   digit_en   - per-digit enable, 0 forces the digit dark
//   data       - registered nibble for the active digit
//   select     - registered one-hot digit select (00 when blanked)
//   frame_done - one-cycle pulse as the scan wraps from digit 7 to 0
// Revision    : 1.0 - initial release
//============================================================================
module segment_scan
    import segment_pkg::*;
#(
    parameter int SCAN_DIV = SCAN_DIV_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [VALUE_W-1:0]  value,
    input  logic                blank_lz,
    input  logic [DIGITS-1:0]   digit_en,
    output logic [NIBBLE_W-1:0] data,
    output logic [DIGITS-1:0]   select,
    output logic                frame_done
);

    localparam digit_idx_t C_LAST_IDX = IDX_W'(DIGITS - 1);

    logic               w_tick;
    logic               w_frame_end;
    digit_idx_t         r_idx;
    logic [VALUE_W-1:0] r_active;
    logic [VALUE_W-1:0] r_pending;
    logic               r_pending_vld;
    logic [DIGITS-1:0]  w_tail_zero;
    logic               w_blank;
    nibble_t            w_nibble;
    logic [DIGITS-1:0]  w_onehot;
    nibble_t            r_data;
    logic [DIGITS-1:0]  r_select;
    logic               r_frame_done;

    scan_prescaler #(
        .DIV (SCAN_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    assign w_frame_end = w_tick && (r_idx == C_LAST_IDX);

    // Digit index advances once per slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
        end else if (w_tick) begin
            r_idx <= r_idx + IDX_W'(1);
        end
    end

    // Loads are parked in the pending register and only promoted to the
    // displayed value at the frame boundary, so a frame never mixes two
    // values. A load landing exactly on the boundary goes straight in.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active      <= '0;
            r_pending     <= '0;
            r_pending_vld <= 1'b0;
        end else if (w_frame_end) begin
            if (load) begin
                r_active <= value;
            end else if (r_pending_vld) begin
                r_active <= r_pending;
            end
            r_pending_vld <= 1'b0;
        end else if (load) begin
            r_pending     <= value;
            r_pending_vld <= 1'b1;
        end
    end

    // w_tail_zero[i]: nibbles i..7 of the active value are all zero.
    for (genvar i = 0; i < DIGITS; i++) begin : g_tail
        assign w_tail_zero[i] = (r_active[VALUE_W-1:i*NIBBLE_W] == '0);
    end

    always_comb begin
        w_nibble = nibble_at(r_active, r_idx);
        w_onehot = DIGITS'(1) << r_idx;
        w_blank  = !digit_en[r_idx] ||
                   (blank_lz && (r_idx != '0) && w_tail_zero[r_idx]);
    end

    // Outputs are registered; a blanked digit still drives its nibble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data       <= '0;
            r_select     <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_data       <= w_nibble;
            r_select     <= w_blank ? '0 : w_onehot;
            r_frame_done <= w_frame_end;
        end
    end

    assign data       = r_data;
    assign select     = r_select;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_segment_scan.sv
`default_nettype none
//============================================================================
// Module      : tb_segment_scan
// Description : Self-checking bench for segment_scan (SCAN_DIV = 4).
//               Directed scenarios followed by random traffic, all compared
//               every cycle against a frame/slot-level reference model.
// Revision    : 1.0 - initial release
//============================================================================
module tb_segment_scan;

    localparam int DIV   = 4;
    localparam int FRAME = 8 * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [31:0] value;
    logic        blank_lz;
    logic [7:0]  digit_en;
    logic [3:0]  data;
    logic [7:0]  select;
    logic        frame_done;

    int errors = 0;
    int checks = 0;

    // Reference model state: cycles since reset and the values in play.
    int          m_n;
    logic [31:0] m_active;
    logic [31:0] m_pending;
    bit          m_pvld;

    segment_scan #(
        .SCAN_DIV (DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value      (value),
        .blank_lz   (blank_lz),
        .digit_en   (digit_en),
        .data       (data),
        .select     (select),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_select(input int idx, input logic [31:0] act,
                                              input logic [7:0] den, input bit blz);
        logic [31:0] tail;
        tail = act >> (4 * idx);
        if (den[idx] == 1'b0) return 8'h00;
        if (blz && idx > 0 && tail == 32'h0) return 8'h00;
        return 8'h01 << idx;
    endfunction

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s n=%0d observed=%h expected=%h", tag, m_n, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s n=%0d observed=%h expected=%h", tag, m_n, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance model, compare all outputs after the edge.
    task automatic cycle(input bit r, input bit ld, input logic [31:0] v);
        int          idx;
        bit          tick;
        logic [3:0]  e_data;
        logic [7:0]  e_sel;
        logic        e_fd;
        rst   = r;
        load  = ld;
        value = v;
        if (r) begin
            e_data = 4'h0; e_sel = 8'h00; e_fd = 1'b0;
            m_n = 0; m_active = 32'h0; m_pending = 32'h0; m_pvld = 1'b0;
        end else begin
            idx    = (m_n / DIV) % 8;
            tick   = (m_n % DIV) == DIV - 1;
            e_data = m_active[4*idx +: 4];
            e_sel  = ref_select(idx, m_active, digit_en, blank_lz);
            e_fd   = tick && idx == 7;
            if (tick && idx == 7) begin
                if (ld)          m_active = v;
                else if (m_pvld) m_active = m_pending;
                m_pvld = 1'b0;
            end else if (ld) begin
                m_pending = v;
                m_pvld    = 1'b1;
            end
            m_n++;
        end
        @(posedge clk);
        #1;
        chk4("data", data, e_data);
        chk8("select", select, e_sel);
        chk4("frame_done", {3'b0, frame_done}, {3'b0, e_fd});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0);
    endtask

    // Idle until the model's frame position equals pos (bounded by one frame).
    task automatic idle_to(input int pos);
        for (int i = 0; i < FRAME && (m_n % FRAME) != pos; i++) cycle(1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; value = 32'h0; blank_lz = 1'b0; digit_en = 8'hFF;
        m_n = 0; m_active = 32'h0; m_pending = 32'h0; m_pvld = 1'b0;
        @(negedge clk);

        // Reset state.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 32'hDEADBEEF);
        chk8("reset_select", select, 8'h00);
        chk4("reset_data", data, 4'h0);

        // First cycle after reset: digit 0 lit showing 0.
        cycle(1'b0, 1'b0, 32'h0);
        chk8("post_reset_select", select, 8'h01);
        chk4("post_reset_data", data, 4'h0);

        // Scan order with a full-frame value.
        cycle(1'b0, 1'b1, 32'h87654321);
        idle(2 * FRAME);
        idle_to(1);
        chk8("scan_digit0_select", select, 8'h01);
        chk4("scan_digit0_data", data, 4'h1);

        // Tear-free update: load during digit 3.
        idle_to(3 * DIV + 1);
        cycle(1'b0, 1'b1, 32'hAAAAAAAA);
        idle(2 * FRAME);

        // Leading-zero blanking.
        blank_lz = 1'b1;
        cycle(1'b0, 1'b1, 32'h00000305);
        idle(2 * FRAME);
        cycle(1'b0, 1'b1, 32'h00000000);
        idle(2 * FRAME);
        blank_lz = 1'b0;

        // Two loads, the second on the index-7 tick.
        idle_to(FRAME - 2);
        cycle(1'b0, 1'b1, 32'h11111111);
        cycle(1'b0, 1'b1, 32'h22222222);
        idle(FRAME + 2);

        // Digit enable mask.
        digit_en = 8'b11110101;
        cycle(1'b0, 1'b1, 32'h76543210);
        idle(2 * FRAME);
        digit_en = 8'hFF;

        // Reset during digit 5 with a pending load.
        idle_to(5 * DIV);
        cycle(1'b0, 1'b1, 32'h99999999);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        idle(2 * FRAME);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            bit          r;
            bit          ld;
            logic [31:0] v;
            if (i % 64 == 0) begin
                digit_en = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
                blank_lz = 1'($urandom_range(0, 1));
            end
            r  = ($urandom_range(0, 299) == 0);
            ld = ($urandom_range(0, 7) == 0);
            v  = $urandom >> (4 * $urandom_range(0, 7));
            cycle(r, ld, v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/segment_scan.md
SEGMENT_SCAN -- requirements
Module: segment_scan

Interface
REQ-001 The module SHALL have parameter SCAN_DIV, default 50000, meaning clock cycles per digit slot (minimum 2).
REQ-002 The module SHALL have port clk, input, 1, the single system clock; all logic is clocked on its rising edge.
REQ-003 The module SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 The module SHALL have port load, input, 1, a one-cycle strobe that captures value.
REQ-005 The module SHALL have port value, input, 32, eight hex nibbles; nibble i is value[4i+3:4i].
REQ-006 The module SHALL have port blank_lz, input, 1; high enables leading-zero blanking.
REQ-007 The module SHALL have port digit_en, input, 8, a per-digit enable mask; 0 forces that digit dark.
REQ-008 The module SHALL have port data, output, 4, the nibble for the active digit, feeding the segment decoder.
REQ-009 The module SHALL have port select, output, 8, active-high digit select; at most one bit set.
REQ-010 The module SHALL have port frame_done, output, 1, a one-cycle pulse when the scan wraps from digit 7 to digit 0.

Function
REQ-011 A prescaler SHALL count 0..SCAN_DIV-1 and wrap; tick is asserted in the cycle the count equals SCAN_DIV-1.
REQ-012 A 3-bit digit index SHALL advance on tick, wrapping 7 -> 0.
REQ-013 Displayed data SHALL come from an active register, never directly from value.
REQ-014 On load, value SHALL be captured into a pending register and a pending flag set; when load repeats before a frame boundary, the last value wins.
REQ-015 On a tick with index 7: if load is high, active <= value; else if pending is set, active <= pending. The pending flag SHALL then clear, so updates never tear mid-frame.
REQ-016 frame_done SHALL pulse in the cycle after a tick at index 7, aligned with the first cycle of digit 0.
REQ-017 data and select SHALL be registered, with one-cycle latency from the index/active state: data = active nibble[idx]; select = one-hot bit idx, or 8'h00 if the digit is blanked.
REQ-018 A digit is blanked if digit_en[idx] = 0, or if blank_lz = 1, idx > 0, and nibbles idx..7 of active are all zero. Digit 0 is never blanked by blank_lz.
REQ-019 When a digit is blanked, data SHALL still carry the nibble; only select is forced to zero.
REQ-020 digit_en and blank_lz SHALL be sampled live each cycle and need no frame alignment.

Reset
REQ-021 While rst is high: prescaler = 0, idx = 0, active = 0, pending = 0, pending flag = 0, data = 4'h0, select = 8'h00, frame_done = 0.
REQ-022 In the first cycle after rst deasserts, data = 4'h0 and select = 8'h01 (unless digit 0 is disabled).
REQ-023 Asserting rst mid-frame SHALL discard any pending load and restart at digit 0 with a full SCAN_DIV slot.
REQ-024 rst SHALL take priority over load.

Structure
REQ-025 SCAN_DIV default, digit count (8) and nibble width (4) SHALL be constants in a shared display package, segment_pkg.
REQ-026 The prescaler SHALL be a sub-module, scan_prescaler (parameter DIV, outputs tick); all other logic stays in segment_scan.
REQ-027 Prescaler width SHALL be $clog2(SCAN_DIV).
REQ-028 data/select SHALL connect directly to the existing static segment decoder's data input and the board digit selects.

Verification
REQ-029 Scan order (SCAN_DIV=4, load 32'h87654321, blank_lz=0, digit_en=FF): after the frame boundary, select = 01,02,04..80, each held 4 cycles, with data = 1,2..8; frame_done pulses once per 32 cycles.
REQ-030 Tear-free update: load 32'hAAAAAAAA while digit 3 is active -> digits 3..7 still show the old nibbles; A appears from the next digit 0.
REQ-031 Leading-zero blanking (blank_lz=1, active 32'h00000305): select = 01,02,04, then 00 for digits 3..7; with value 0, only digit 0 lights, showing 0.
REQ-032 Simultaneous events: load 32'h11111111 and load 32'h22222222 on consecutive cycles, the second coinciding with the index-7 tick -> next frame shows 2 on all digits.
REQ-033 digit_en = 8'b11110101 -> select is 00 during slots 1 and 3 while data still carries those nibbles.
REQ-034 Reset mid-operation: rst pulsed during digit 5 with a pending load -> outputs 0/00 during reset, then select=01, data=0, and the pending value is never displayed.
